// File: rtl/gpio_serial_cfg_rx.sv
// Receive side of the PS->PL GPIO serial config protocol: synchronises gpio_ctrl,
// detects serial clock edges and emits per-register shift strobes and load-done pulses.
module gpio_serial_cfg_rx #(
   parameter int CONFIG_REG_WIDTH = 16,
   parameter int WAVE_WIDTH       = 256,
   parameter int FLAG_REPEAT      = 8,
   parameter int NUM_CHANNELS     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [15:0]             gpio_ctrl,
   output logic [NUM_CHANNELS-1:0] channel_sel,
   output logic                    shift_bit,
   output logic [8:0]              shift_stb,
   output logic [8:0]              load_done,
   output logic                    trigger_pulse,
   output logic                    readout_en,
   output logic                    proto_err
);

   function automatic int reg_len(input int k);
      case (k)
         1, 2:    return WAVE_WIDTH;
         5, 6:    return FLAG_REPEAT;
         default: return CONFIG_REG_WIDTH;
      endcase
   endfunction

   function automatic int max_len();
      int m;
      m = CONFIG_REG_WIDTH;
      if (WAVE_WIDTH > m) m = WAVE_WIDTH;
      if (FLAG_REPEAT > m) m = FLAG_REPEAT;
      return m;
   endfunction

   localparam int CW = $clog2(max_len()) + 1;

   logic [12:0] sync1, sync2;
   logic [11:1] prev, edges;
   logic        collision, sel_fire;
   logic [8:0]  stb_fire, done_fire;
   logic        unused_gpio;

   assign unused_gpio = ^gpio_ctrl[15:13];

   // edges[1] is channel_sel_clk, edges[10:2] the register clocks, edges[11] the trigger
   assign edges      = sync2[11:1] & ~prev;
   assign collision  = $countones(edges[10:1]) > 1;
   assign sel_fire   = edges[1] & ~collision;
   assign stb_fire   = edges[10:2] & {9{~collision}};
   assign readout_en = sync2[12];

   for (genvar k = 0; k < 9; k++) begin : g_cnt
      localparam logic [CW-1:0] LAST = CW'(reg_len(k) - 1);
      logic [CW-1:0] cnt;

      assign done_fire[k] = stb_fire[k] && (cnt == LAST);

      always_ff @(posedge clk) begin
         if (rst || sel_fire)   cnt <= '0;
         else if (done_fire[k]) cnt <= '0;
         else if (stb_fire[k])  cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1         <= '0;
         sync2         <= '0;
         prev          <= '0;
         channel_sel   <= '0;
         shift_bit     <= 1'b0;
         shift_stb     <= '0;
         load_done     <= '0;
         trigger_pulse <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         sync1         <= gpio_ctrl[12:0];
         sync2         <= sync1;
         prev          <= sync2[11:1];
         shift_stb     <= stb_fire;
         load_done     <= done_fire;
         trigger_pulse <= edges[11];
         if (sel_fire)
            channel_sel <= {sync2[0], channel_sel[NUM_CHANNELS-1:1]};
         if (|stb_fire)
            shift_bit <= sync2[0];
         // strobes still go out with a bad select; the flag records it
         if (collision || ((|stb_fire) && !$onehot(channel_sel)))
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gpio_serial_cfg_rx.sv
// Bench for gpio_serial_cfg_rx: table of channel-select vectors plus serial load
// sequences checked against a strobe scoreboard.
module tb_gpio_serial_cfg_rx;

   localparam int LEN [0:8] = '{16, 256, 256, 16, 16, 8, 8, 16, 16};

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] gpio_ctrl;
   logic [15:0] channel_sel;
   logic        shift_bit;
   logic [8:0]  shift_stb;
   logic [8:0]  load_done;
   logic        trigger_pulse;
   logic        readout_en;
   logic        proto_err;

   gpio_serial_cfg_rx dut (
      .clk(clk), .rst(rst), .gpio_ctrl(gpio_ctrl), .channel_sel(channel_sel),
      .shift_bit(shift_bit), .shift_stb(shift_stb), .load_done(load_done),
      .trigger_pulse(trigger_pulse), .readout_en(readout_en), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   typedef struct { int k; logic b; logic d; int cyc; } sb_t;
   typedef struct { logic [15:0] bits; logic [15:0] exp_sel; } sel_vec_t;

   sb_t sb[$];
   int  nvec = 0, nerr = 0, cyc = 0, trig_cnt = 0;
   int  mcnt [0:8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (!rst) begin
         if (trigger_pulse) trig_cnt++;
         if (shift_stb != '0 || load_done != '0) begin
            if (sb.size() == 0)
               chk("unexpected_strobe", {14'd0, shift_stb, load_done}, 32'd0);
            else begin
               e = sb.pop_front();
               chk("stb_cycle", cyc, e.cyc);
               chk("stb_vec", 32'(shift_stb), 32'(1) << e.k);
               chk("stb_bit", 32'(shift_bit), 32'(e.b));
               chk("load_done", 32'(load_done), e.d ? (32'(1) << e.k) : 32'd0);
            end
         end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("stb_missing", 32'(shift_stb), 32'(1) << e.k);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // one serial clock period on gpio line 'line' carrying sdata 'b'
   task automatic send_edge(input int line, input logic b);
      sb_t e;
      gpio_ctrl[0] = b;
      tick(2);
      gpio_ctrl[line] = 1'b1;
      if (line == 1) begin
         foreach (mcnt[i]) mcnt[i] = 0;
      end else begin
         e.k = line - 2;
         mcnt[e.k]++;
         e.d = (mcnt[e.k] == LEN[e.k]);
         if (e.d) mcnt[e.k] = 0;
         e.b = b;
         e.cyc = cyc + 3;
         sb.push_back(e);
      end
      tick(2);
      gpio_ctrl[line] = 1'b0;
      tick(2);
   endtask

   task automatic drained(input string name);
      tick(2);
      chk(name, sb.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      foreach (mcnt[i]) mcnt[i] = 0;
      sb.delete();
   endtask

   task automatic select(input logic [15:0] bits);
      for (int n = 0; n < 16; n++) send_edge(1, bits[n]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sel_vec_t    tbl [0:4];
      logic [15:0] val;
      tbl[0] = '{16'h0020, 16'h0020};
      tbl[1] = '{16'h8000, 16'h8000};
      tbl[2] = '{16'h0001, 16'h0001};
      tbl[3] = '{16'hA5C3, 16'hA5C3};
      tbl[4] = '{16'h0008, 16'h0008};
      foreach (mcnt[i]) mcnt[i] = 0;

      rst = 1'b1;
      gpio_ctrl = '0;
      tick(3);
      chk("rst_channel_sel", channel_sel, 0);
      chk("rst_shift_stb", shift_stb, 0);
      chk("rst_load_done", load_done, 0);
      chk("rst_shift_bit", shift_bit, 0);
      chk("rst_trigger", trigger_pulse, 0);
      chk("rst_readout", readout_en, 0);
      chk("rst_proto_err", proto_err, 0);
      rst = 1'b0;
      tick(2);

      foreach (tbl[i]) begin
         select(tbl[i].bits);
         chk("channel_sel", channel_sel, tbl[i].exp_sel);
         chk("sel_no_err", proto_err, 0);
      end

      // numeric load of 10, LSB first
      val = 16'd10;
      for (int n = 0; n < 16; n++) send_edge(2, val[n]);
      drained("numeric_drain");

      // wave load: 128 ones then 128 zeros, then a flag load
      for (int n = 0; n < 256; n++) send_edge(3, n < 128);
      drained("wave_drain");
      for (int n = 0; n < 8; n++) send_edge(7, 1'b1);
      drained("flag_drain");
      chk("load_no_err", proto_err, 0);

      gpio_ctrl[12] = 1'b1;
      tick(1);
      chk("readout_early", readout_en, 0);
      tick(1);
      chk("readout_on", readout_en, 1);
      gpio_ctrl[12] = 1'b0;

      trig_cnt = 0;
      gpio_ctrl[11] = 1'b1;
      tick(2);
      gpio_ctrl[11] = 1'b0;
      tick(6);
      chk("trigger_once", trig_cnt, 1);

      // abort via channel select
      for (int n = 0; n < 7; n++) send_edge(2, 1'b1);
      send_edge(1, 1'b0);
      for (int n = 0; n < 16; n++) send_edge(2, n[0]);
      drained("abort_sel_drain");
      chk("abort_channel_sel", channel_sel, 16'h0004);
      chk("abort_no_err", proto_err, 0);

      // abort via reset; strobes with empty select raise the flag
      for (int n = 0; n < 7; n++) send_edge(2, 1'b0);
      do_reset();
      chk("rst_clears_sel", channel_sel, 0);
      for (int n = 0; n < 16; n++) send_edge(2, 1'b1);
      drained("abort_rst_drain");
      chk("err_not_onehot", proto_err, 1);

      do_reset();
      select(16'h0008);
      chk("reselect_no_err", proto_err, 0);

      // collision of mask_clk and pre_delay_cycle_clk, trigger alongside
      for (int n = 0; n < 5; n++) send_edge(5, 1'b1);
      trig_cnt = 0;
      gpio_ctrl[0] = 1'b0;
      tick(2);
      gpio_ctrl[3] = 1'b1;
      gpio_ctrl[5] = 1'b1;
      gpio_ctrl[11] = 1'b1;
      tick(2);
      gpio_ctrl[3] = 1'b0;
      gpio_ctrl[5] = 1'b0;
      gpio_ctrl[11] = 1'b0;
      tick(4);
      chk("collision_err", proto_err, 1);
      chk("collision_trigger", trig_cnt, 1);
      for (int n = 0; n < 11; n++) send_edge(5, 1'b0);
      drained("collision_drain");
      tick(20);
      chk("err_sticky", proto_err, 1);
      do_reset();
      tick(1);
      chk("err_cleared", proto_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/gpio_serial_cfg_rx.md
# gpio_serial_cfg_rx

Receive end of the GPIO serial configuration protocol that the PS uses to program the DAC/ADC channel drivers. The block synchronises the 16-bit `gpio_ctrl` bus and detects rising edges on the per-register serial clock lines. It maintains the one-hot channel select and emits single-cycle shift strobes, the sampled data bit, and per-register load-complete pulses. These outputs feed the per-channel configuration shift registers inside `rfsoc_pl_ctrl`.

## Interface
Parameters:
- `CONFIG_REG_WIDTH`, 16: bit length of numeric config registers (cycle count, pre/post delay, ADC run cycles, ADC shift value).
- `WAVE_WIDTH`, 256: bit length of the mask and locking-waveform registers.
- `FLAG_REPEAT`, 8: serial clock edges per single-bit flag load (mux select, mask enable).
- `NUM_CHANNELS`, 16: number of selectable channels.

GPIO bit map (fixed): 0 `sdata`, 1 `channel_sel_clk`, 2 `cycle_count_clk`, 3 `mask_clk`, 4 `locking_waveform_clk`, 5 `pre_delay_cycle_clk`, 6 `post_delay_cycle_clk`, 7 `mux_set_clk`, 8 `mask_enable_clk`, 9 `adc_num_cycle_count_clk`, 10 `adc_shift_val_clk`, 11 `trigger_line`, 12 `adc_readout_enable`, 13-15 unused.

Ports:
- `clk`  in  1  fabric clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `gpio_ctrl`  in  16  asynchronous GPIO bus from the PS.
- `channel_sel`  out  NUM_CHANNELS  one-hot channel select (bit n = channel n).
- `shift_bit`  out  1  sdata value captured with the current strobe.
- `shift_stb`  out  9  one-cycle shift pulse per register type; index k = GPIO bit k+2.
- `load_done`  out  9  one-cycle pulse when register type k has received its full length.
- `trigger_pulse`  out  1  one-cycle pulse on a trigger_line rising edge.
- `readout_en`  out  1  synchronised adc_readout_enable level.
- `proto_err`  out  1  sticky error flag.

## Operation
- Every `gpio_ctrl` bit passes through a 2-flop synchroniser, followed by a previous-value register. A rising edge is sync=1 and prev=0.
- sdata is sampled from the synchronised stage in the same cycle the clock-line edge is detected.
- Channel select:
  - On a rising edge of channel_sel_clk, `channel_sel <= {sdata, channel_sel[N-1:1]}` (shift right, MSB insert).
  - Therefore after N edges, `channel_sel[n]` holds the bit sent at step n.
  - The same edge clears all nine bit counters.
- Register clocks (k = 0..8):
  - A rising edge pulses `shift_stb[k]` and latches `shift_bit`.
  - It also increments `cnt[k]`.
- Length per type:
  - k = 0, 3, 4, 7, 8: CONFIG_REG_WIDTH.
  - k = 1, 2: WAVE_WIDTH.
  - k = 5, 6: FLAG_REPEAT.
- When an increment reaches the length, `load_done[k]` pulses together with that final `shift_stb[k]`, and `cnt[k]` returns to 0.
- Collision: rising edges on two or more of GPIO bits 1-10 in the same cycle produce no strobes, no channel shift and no counter change. `proto_err` is set.
- `proto_err` is also set when any `shift_stb` fires while `channel_sel` is not exactly one-hot. The strobe is still issued in that case.
- `proto_err` clears only on reset.
- Trigger: a rising edge of trigger_line gives one `trigger_pulse`. It is independent of collisions.

## Timing
- Latency: from a GPIO change at an input flop D to the strobe/pulse output is 3 clk cycles (2 sync + edge register). Strobe outputs are registered.
- sdata must be stable at least 1 cycle before its clock line rises and held at least 1 cycle after. The protocol driver gives 2 cycles each side.
- Minimum serial clock high and low times are 2 clk cycles each. Shorter pulses may be missed; this is not detected.
- Back-to-back edges on the same line are impossible: an edge requires a low cycle in between.
- Reset values:
  - `channel_sel` = 0, `shift_bit` = 0, `shift_stb` = 0, `load_done` = 0, `trigger_pulse` = 0, `readout_en` = 0, `proto_err` = 0.
  - Sync, prev and all counters = 0.
- Reset mid-load discards the partial count.
- On the first cycle after reset, prev = 0. A GPIO line already high at reset release therefore produces one edge after synchronisation. This is accepted behaviour; the driver holds lines low during reset.
- Counter wrap: counter width is clog2(max length)+1. The counter never exceeds its length.

## Test plan
- Channel select: shift 16 bits with 1 at step 5 only -> `channel_sel` = 16'h0020, no `proto_err`. Repeat for step 15 -> 16'h8000.
- Numeric load: select ch 3, send value 10 LSB-first on cycle_count_clk (16 edges) -> 16 `shift_stb[0]` pulses with `shift_bit` sequence 0,1,0,1,0…0. `load_done[0]` pulses exactly once, on edge 16, 3 cycles after the last rising edge.
- Wave load: 256 edges on mask_clk with pattern {8{16'h0000},8{16'hFFFF}} -> 128 ones then 128 zeros on `shift_bit`, and a single `load_done[1]`. After 8 edges on mux_set_clk with sdata=1 -> `load_done[5]` once.
- Collision: raise mask_clk and pre_delay_cycle_clk in the same cycle -> no `shift_stb`, counters unchanged, `proto_err`=1 and it stays 1 until `rst`.
- Abort: 7 cycle_count_clk edges, then one channel_sel_clk edge, then 16 cycle_count_clk edges -> `load_done[0]` only on the 16th edge after the select. A separate 7 edges + `rst` + 16 edges gives the same result.
- Trigger/readout: 1-cycle trigger high (held ≥2 cycles) -> exactly one `trigger_pulse`. `adc_readout_enable`=1 -> `readout_en`=1 after 2 cycles.
